// File: rtl/uk101_video_timing.sv
// Raster timing engine for the UK101 display: pixel enable, sync/blank/DE and
// character-cell coordinates for 64x32 (mode 0) and 48x16 (mode 1) layouts.
module uk101_video_timing #(
  parameter int CE_DIV          = 6,
  parameter int H_ACTIVE        = 384,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 40,
  parameter int H_BP            = 88,
  parameter int V_ACTIVE        = 256,
  parameter int V_FP            = 16,
  parameter int V_SYNC          = 4,
  parameter int V_BP            = 36,
  parameter int CHAR_W0         = 6,
  parameter int CHAR_H0         = 8,
  parameter int CHAR_W1         = 8,
  parameter int CHAR_H1         = 16,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mode,
  output logic       ce_pix,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic [10:0] hcount,
  output logic [9:0] vcount,
  output logic [6:0] char_col,
  output logic [5:0] char_row,
  output logic [3:0] pix_x,
  output logic [4:0] pix_y,
  output logic       mode_active,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST  = 4'(CE_DIV - 1);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  CW0_LAST  = 4'(CHAR_W0 - 1);
  localparam logic [3:0]  CW1_LAST  = 4'(CHAR_W1 - 1);
  localparam logic [4:0]  CH0_LAST  = 5'(CHAR_H0 - 1);
  localparam logic [4:0]  CH1_LAST  = 5'(CHAR_H1 - 1);
  // Last whole cell per line/frame; a trailing partial cell keeps this index.
  localparam logic [6:0]  COL0_LAST = 7'(H_ACTIVE / CHAR_W0 - 1);
  localparam logic [6:0]  COL1_LAST = 7'(H_ACTIVE / CHAR_W1 - 1);
  localparam logic [5:0]  ROW0_LAST = 6'(V_ACTIVE / CHAR_H0 - 1);
  localparam logic [5:0]  ROW1_LAST = 6'(V_ACTIVE / CHAR_H1 - 1);
  localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [3:0]  r_div;
  logic        r_ce;
  logic        r_run;
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblank;
  logic        r_vblank;
  logic        r_de;
  logic [6:0]  r_char_col;
  logic [5:0]  r_char_row;
  logic [3:0]  r_pix_x;
  logic [4:0]  r_pix_y;
  logic        r_mode_active;
  logic        r_frame_start;

  logic        w_tick;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_hblank_nxt;
  logic        w_vblank_nxt;
  logic        w_hsync_on;
  logic        w_vsync_on;
  logic [3:0]  w_cw_last;
  logic [4:0]  w_ch_last;
  logic [6:0]  w_col_last;
  logic [5:0]  w_row_last;
  logic [3:0]  w_pix_x_nxt;
  logic [6:0]  w_char_col_nxt;
  logic [4:0]  w_pix_y_nxt;
  logic [5:0]  w_char_row_nxt;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_h_wrap = (r_hcount == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_vcount == V_LAST);
  assign w_h_nxt  = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
  assign w_v_nxt  = w_v_wrap ? 10'd0 : (w_h_wrap ? r_vcount + 10'd1 : r_vcount);

  assign w_hblank_nxt = (w_h_nxt >= H_ACT);
  assign w_vblank_nxt = (w_v_nxt >= V_ACT);
  assign w_hsync_on   = (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
  assign w_vsync_on   = (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);

  assign w_cw_last  = r_mode_active ? CW1_LAST  : CW0_LAST;
  assign w_ch_last  = r_mode_active ? CH1_LAST  : CH0_LAST;
  assign w_col_last = r_mode_active ? COL1_LAST : COL0_LAST;
  assign w_row_last = r_mode_active ? ROW1_LAST : ROW0_LAST;

  // Cell coordinates for the next raster position; they only move inside
  // active video and hold their last value elsewhere.
  always_comb begin
    w_pix_x_nxt    = r_pix_x;
    w_char_col_nxt = r_char_col;
    w_pix_y_nxt    = r_pix_y;
    w_char_row_nxt = r_char_row;
    if (w_h_nxt == 11'd0) begin
      w_pix_x_nxt    = 4'd0;
      w_char_col_nxt = 7'd0;
    end else if (!w_hblank_nxt && !w_vblank_nxt) begin
      if (r_pix_x == w_cw_last) begin
        w_pix_x_nxt = 4'd0;
        if (r_char_col != w_col_last) w_char_col_nxt = r_char_col + 7'd1;
      end else begin
        w_pix_x_nxt = r_pix_x + 4'd1;
      end
    end
    if (w_h_wrap) begin
      if (w_v_nxt == 10'd0) begin
        w_pix_y_nxt    = 5'd0;
        w_char_row_nxt = 6'd0;
      end else if (!w_vblank_nxt) begin
        if (r_pix_y == w_ch_last) begin
          w_pix_y_nxt = 5'd0;
          if (r_char_row != w_row_last) w_char_row_nxt = r_char_row + 6'd1;
        end else begin
          w_pix_y_nxt = r_pix_y + 5'd1;
        end
      end
    end
  end

  // The first pixel tick after reset presents position (0,0) instead of
  // advancing, so consumers see the origin with frame_start.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div         <= 4'd0;
      r_ce          <= 1'b0;
      r_run         <= 1'b0;
      r_hcount      <= 11'd0;
      r_vcount      <= 10'd0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_de          <= 1'b1;
      r_char_col    <= 7'd0;
      r_char_row    <= 6'd0;
      r_pix_x       <= 4'd0;
      r_pix_y       <= 5'd0;
      r_mode_active <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? 4'd0 : r_div + 4'd1;
      r_ce          <= w_tick;
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_run <= 1'b1;
        if (!r_run) begin
          r_frame_start <= 1'b1;
        end else begin
          r_hcount      <= w_h_nxt;
          r_vcount      <= w_v_nxt;
          r_hblank      <= w_hblank_nxt;
          r_vblank      <= w_vblank_nxt;
          r_de          <= !(w_hblank_nxt || w_vblank_nxt);
          r_hsync       <= w_hsync_on ? !SYNC_IDLE : SYNC_IDLE;
          r_vsync       <= w_vsync_on ? !SYNC_IDLE : SYNC_IDLE;
          r_pix_x       <= w_pix_x_nxt;
          r_char_col    <= w_char_col_nxt;
          r_pix_y       <= w_pix_y_nxt;
          r_char_row    <= w_char_row_nxt;
          r_frame_start <= (w_h_nxt == 11'd0) && (w_v_nxt == 10'd0);
          if (w_v_wrap) r_mode_active <= mode;
        end
      end
    end
  end

  assign ce_pix      = r_ce;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign de          = r_de;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign char_col    = r_char_col;
  assign char_row    = r_char_row;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign mode_active = r_mode_active;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_uk101_video_timing.sv
// Bench for uk101_video_timing on a shrunken 20x22 raster: scoreboarded
// per-pixel expectations, mid-frame mode switch, async reset and CE_DIV=1.
module tb_uk101_video_timing;

  localparam int N_TICKS   = 900;
  localparam int MODE_TICK = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic mode1 = 1'b0;

  logic ce_pix, hsync, vsync, hblank, vblank, de, mode_active, frame_start;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [6:0]  char_col;
  logic [5:0]  char_row;
  logic [3:0]  pix_x;
  logic [4:0]  pix_y;

  logic ce1, hs1, vs1, hb1, vb1, de1, ma1, fs1;
  logic [10:0] hc1;
  logic [9:0]  vc1;
  logic [6:0]  col1;
  logic [5:0]  row1;
  logic [3:0]  px1;
  logic [4:0]  py1;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        de;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [3:0]  px;
    logic [4:0]  py;
    logic        md;
    logic        fs;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tick_no = 0;
  int last_ce = -1;
  int last_fs1 = -1;
  int ce1_low = 0;
  logic mon_en = 1'b1;

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- DUTs ----------------
  uk101_video_timing #(
    .CE_DIV(3), .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CHAR_W0(3), .CHAR_H0(4), .CHAR_W1(5), .CHAR_H1(8), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk_sys(clk), .reset(reset), .mode(mode), .ce_pix(ce_pix),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
    .hcount(hcount), .vcount(vcount), .char_col(char_col), .char_row(char_row),
    .pix_x(pix_x), .pix_y(pix_y), .mode_active(mode_active),
    .frame_start(frame_start)
  );

  uk101_video_timing #(
    .CE_DIV(1), .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CHAR_W0(3), .CHAR_H0(4), .CHAR_W1(5), .CHAR_H1(8), .SYNC_ACTIVE_LOW(1)
  ) dut1 (
    .clk_sys(clk), .reset(reset), .mode(mode1), .ce_pix(ce1),
    .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1), .de(de1),
    .hcount(hc1), .vcount(vc1), .char_col(col1), .char_row(row1),
    .pix_x(px1), .pix_y(py1), .mode_active(ma1), .frame_start(fs1)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raster of 20 pixels x 22 lines: hsync pixels 14..16, vsync lines 18..19.
  task automatic build_expected();
    int h, v, md, col, row, px, py, cw, ch, mc, mr;
    exp_t e;
    h = 0; v = 0; md = 0; col = 0; row = 0; px = 0; py = 0;
    for (int k = 0; k < N_TICKS; k++) begin
      if (k > 0) begin
        h++;
        if (h == 20) begin
          h = 0;
          v++;
          if (v == 22) begin
            v  = 0;
            md = (k > MODE_TICK) ? 1 : 0;
          end
        end
      end
      cw = md ? 5 : 3;
      ch = md ? 8 : 4;
      mc = 12 / cw - 1;
      mr = 16 / ch - 1;
      if (h == 0 && v < 16) begin
        py  = v % ch;
        row = (v / ch > mr) ? mr : v / ch;
      end
      if (h == 0) begin
        px = 0; col = 0;
      end else if (h < 12 && v < 16) begin
        px  = h % cw;
        col = (h / cw > mc) ? mc : h / cw;
      end
      e.h   = 11'(h);
      e.v   = 10'(v);
      e.hs  = !(h >= 14 && h < 17);
      e.vs  = !(v >= 18 && v < 20);
      e.hb  = (h >= 12);
      e.vb  = (v >= 16);
      e.de  = !((h >= 12) || (v >= 16));
      e.col = 7'(col);
      e.row = 6'(row);
      e.px  = 4'(px);
      e.py  = 5'(py);
      e.md  = md[0];
      e.fs  = (h == 0 && v == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ce_pix"}, int'(ce_pix), 0);
    chk({tag, "_hcount"}, int'(hcount), 0);
    chk({tag, "_vcount"}, int'(vcount), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_hblank"}, int'(hblank), 0);
    chk({tag, "_vblank"}, int'(vblank), 0);
    chk({tag, "_de"}, int'(de), 1);
    chk({tag, "_char_col"}, int'(char_col), 0);
    chk({tag, "_char_row"}, int'(char_row), 0);
    chk({tag, "_pix_x"}, int'(pix_x), 0);
    chk({tag, "_pix_y"}, int'(pix_y), 0);
    chk({tag, "_mode_active"}, int'(mode_active), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  // ---------------- scoreboard monitor (CE_DIV=3 instance) ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mon_en && ce_pix) begin
      if (last_ce < 0) chk("ce_first_edge", cyc, 3);
      else             chk("ce_gap", cyc - last_ce, 3);
      last_ce = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: ce_pix with no expectation at tick %0d", tick_no);
      end else begin
        e = exp_q.pop_front();
        chk("hcount", int'(hcount), int'(e.h));
        chk("vcount", int'(vcount), int'(e.v));
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("hblank", int'(hblank), int'(e.hb));
        chk("vblank", int'(vblank), int'(e.vb));
        chk("de", int'(de), int'(e.de));
        chk("char_col", int'(char_col), int'(e.col));
        chk("char_row", int'(char_row), int'(e.row));
        chk("pix_x", int'(pix_x), int'(e.px));
        chk("pix_y", int'(pix_y), int'(e.py));
        chk("mode_active", int'(mode_active), int'(e.md));
        chk("frame_start", int'(frame_start), int'(e.fs));
      end
      tick_no++;
    end
  end

  // ---------------- monitor (CE_DIV=1 instance) ----------------
  always @(negedge clk) begin
    if (!reset && mon_en && cyc >= 1) begin
      if (!ce1) ce1_low++;
      if (fs1) begin
        if (last_fs1 < 0) chk("ce1_first_frame_start", cyc, 1);
        else              chk("ce1_frame_period", cyc - last_fs1, 440);
        last_fs1 = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    build_expected();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    chk("por_ce1", int'(ce1), 0);
    chk("por_hcount1", int'(hc1), 0);

    @(posedge clk);
    #2 reset = 1'b0;

    // Switch layout mid-frame (line 10); it must only apply at the next frame.
    repeat (3 * (MODE_TICK + 1)) @(posedge clk);
    #1 mode = 1'b1;
    repeat (3 * N_TICKS - 3 * (MODE_TICK + 1)) @(posedge clk);
    @(negedge clk);
    #1 mon_en = 1'b0;

    chk("queue_drained", exp_q.size(), 0);
    chk("ce1_always_high", ce1_low, 0);

    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hcount == 11'd15) begin
        found = 1'b1;
        break;
      end
    end
    chk("hsync_window_reached", int'(found), 1);
    if (found) begin
      chk("pre_reset_hsync", int'(hsync), 0);
      chk("pre_reset_mode_active", int'(mode_active), 1);
      #2 reset = 1'b1;
      #1 check_reset_values("async");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uk101_video_timing.md
# uk101_video_timing

Parametrised video timing generator for the UK101 core, replacing the fixed divide-by-6 pixel enable in the top level with a full raster engine. It produces the pixel clock enable, sync, blanking and data-enable signals, as well as character-cell coordinates for the display RAM and character ROM fetch logic. Two character layouts are supported: 64x32 and 48x16. The layout is selected at run time and switches only on frame boundaries. Outputs feed video_cleaner and video_mixer directly.

## Interface
Parameters:
- CE_DIV, 6: clk_sys cycles per pixel (1..16).
- H_ACTIVE, 384: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 40: horizontal sync width, in pixels.
- H_BP, 88: horizontal back porch, in pixels.
- V_ACTIVE, 256: active lines per frame.
- V_FP, 16: vertical front porch, in lines.
- V_SYNC, 4: vertical sync width, in lines.
- V_BP, 36: vertical back porch, in lines.
- CHAR_W0 / CHAR_H0, 6 / 8: cell size for mode 0 (64x32).
- CHAR_W1 / CHAR_H1, 8 / 16: cell size for mode 1 (48x16).
- SYNC_ACTIVE_LOW, 1: when 1, hsync and vsync are low during sync.

Ports:
- clk_sys, input, 1: system clock (50 MHz).
- reset, input, 1: asynchronous, active-high reset.
- mode, input, 1: layout request (0 = 64x32, 1 = 48x16).
- ce_pix, output, 1: pixel enable, one clk_sys cycle wide.
- hsync / vsync, output, 1 each: sync outputs, polarity set by SYNC_ACTIVE_LOW.
- hblank / vblank, output, 1 each: blanking outputs, active high.
- de, output, 1: ~(hblank | vblank).
- hcount, output, 11: pixel counter, 0..H_TOTAL-1.
- vcount, output, 10: line counter, 0..V_TOTAL-1.
- char_col, output, 7: character column. Frozen outside active video.
- char_row, output, 6: character row. Frozen outside active video.
- pix_x, output, 4: pixel index within the cell.
- pix_y, output, 5: line index within the cell.
- mode_active, output, 1: the mode currently in effect.
- frame_start, output, 1: one-cycle pulse on the ce_pix where hcount=0 and vcount=0.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (528). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (312).
- Divider counts 0..CE_DIV-1. ce_pix is registered high in the cycle after the divider equals CE_DIV-1. When CE_DIV=1, ce_pix is high every cycle after reset.
- All counters and raster outputs update only on ce_pix. Between updates they hold.
- hcount wraps from H_TOTAL-1 to 0 and increments vcount at the same time. vcount wraps from V_TOTAL-1 to 0.
- hblank = hcount >= H_ACTIVE.
- hsync is active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vblank and vsync are decoded the same way from vcount.
- Cell counters use no division:
  - pix_x counts 0..CW-1. On wrap it increments char_col.
  - pix_x and char_col clear at hcount=0.
  - pix_y counts 0..CH-1 and advances at the end of each active line. On wrap it increments char_row.
  - pix_y and char_row clear at frame start.
- CW and CH come from mode_active.
- Mode switching: mode is sampled only on the ce_pix that wraps vcount to 0, and loads mode_active there. A mode change mid-frame has no effect until the next frame. The first frame after reset uses mode_active=0.
- Active pixels per row in mode 0 are 384/6 = 64 columns, and 256/8 = 32 rows. If H_ACTIVE is not a multiple of CW, char_col saturates at its last value for the partial cell.

## Timing
- All outputs are registered.
- Reset values:
  - ce_pix=0.
  - hcount=vcount=0.
  - Cell counters=0.
  - hblank=vblank=0, de=1.
  - hsync=vsync inactive level.
  - mode_active=0, frame_start=0.
- Reset is asynchronous and takes effect immediately at any point, including mid-line or mid-sync. It is released synchronously with clk_sys.
- The first ce_pix after reset release occurs on the CE_DIV-th rising edge.
- All raster outputs change in the same cycle that ce_pix is high. Consumers sample them on ce_pix.
- frame_start coincides exactly with the ce_pix on which the counters are at (0,0).
- Simultaneous hcount wrap and vcount wrap: both apply on the same edge, and frame_start is asserted.

## Test plan
- Reset with default parameters, then release -> ce_pix high on clk_sys edges 6, 12, 18…; hcount is 1 at the second ce_pix.
- Run one full frame -> 528×312 = 164736 ce_pix pulses between frame_start pulses. Within each line, hsync is low for exactly 40 ce_pix pulses beginning at hcount 400. Within each frame, vsync is low for exactly 4 lines beginning at vcount 272.
- Mode 0, active region -> char_col steps 0..63 with pix_x wrapping every 6 pixels; char_row reaches 31 with pix_y wrapping every 8 lines. de is high for exactly 384×256 ce_pix pulses.
- Toggle mode to 1 at vcount 100 -> mode_active stays 0 until the next frame_start. After that, the frame has char_col max 47, char_row max 15, pix_x wrapping every 8 pixels, and pix_y wrapping every 16 lines.
- Assert reset at hcount 410 during hsync -> hsync returns to inactive with no clock edge needed, and all counters read 0.
- CE_DIV=1 instance -> ce_pix is constantly high from the first edge after reset, and the frame period is 164736 clk_sys cycles.
